edge_event_arbiter: RTL
=======================

// Module: edge_event_arbiter
// PURPOSE
//   Collects one-cycle rising/falling edge pulses from NUM_CH input conditioners and
//   round-robin arbitrates them into a single event FIFO. Downstream logic reads
//   events (channel, direction) over a valid/ready handshake. Sits between the bank
//   of input conditioners and the command/scan logic, so no edge is dropped silently.
// PARAMETERS
//   NUM_CH      4   number of conditioned input channels (>=2)
//   FIFO_DEPTH  4   event FIFO entries (power of 2, >=2)
//   TS_WIDTH    8   timestamp counter width (used only with EDGE_EVENT_TS_EN)
// PORTS
//   clk             in   1              system clock, all logic on posedge
//   reset_n         in   1              asynchronous, active-low reset
//   rise_in         in   NUM_CH         per-channel positiveedge pulses
//   fall_in         in   NUM_CH         per-channel negativeedge pulses
//   evt_valid       out  1              FIFO head holds an event
//   evt_ready       in   1              consumer accepts head this cycle
//   evt_channel     out  CHW            channel index of head, CHW=clog2(NUM_CH)
//   evt_rising      out  1              1 = rising edge, 0 = falling edge
//   evt_timestamp   out  TS_WIDTH       capture time of head (EDGE_EVENT_TS_EN only)
//   fifo_count      out  clog2(D)+1     current occupancy, 0..FIFO_DEPTH
//   overflow        out  1              sticky: an edge was lost
//   overflow_clr    in   1              synchronous clear of overflow
// BEHAVIOUR
//   - Reset (async, reset_n=0): pending bits, FIFO pointers, rr pointer, overflow,
//     timestamp cleared; evt_valid=0, evt_channel=0, evt_rising=0, fifo_count=0
//     immediately, not at next edge. Any in-flight pending edge is discarded.
//   - Request vector req[2*NUM_CH]: bit 2*c = pend_rise[c], bit 2*c+1 = pend_fall[c].
//   - Pulse on rise_in[c]/fall_in[c] at edge t sets the pending bit at t.
//   - Grant: if any req and FIFO not full, pick first set bit at or after rr_ptr
//     (wrapping 2*NUM_CH-1 -> 0); at next edge push {c, dir}, clear that bit,
//     rr_ptr <= granted index + 1 (mod 2*NUM_CH). One grant per cycle max.
//   - Latency: pulse at edge t -> pushed at t+1 -> evt_valid=1 after t+1 (FIFO empty).
//   - Same-cycle set and grant-clear on one bit: set wins (new edge stays pending).
//   - Pulse arriving while its pending bit already set (and not granted that cycle):
//     edge lost, overflow <= 1.
//   - FIFO full: no grant; pending bits hold. Push only when not full; no bypass of
//     a simultaneous pop (full + pop -> grant resumes next cycle).
//   - Pop when evt_valid && evt_ready; pointers wrap at FIFO_DEPTH. evt_ready while
//     empty is ignored. Simultaneous push and pop: fifo_count unchanged.
//   - Outputs evt_* are registered FIFO head, stable while evt_valid && !evt_ready.
//   - overflow_clr and a new loss in the same cycle: overflow stays 1.
// CONFIGURATION
//   EDGE_EVENT_TS_EN defined: free-running TS_WIDTH counter (wraps, reset 0); value
//     at grant cycle stored with each event and driven on evt_timestamp.
//   Not defined: no counter, no timestamp storage, evt_timestamp port absent.
// STRUCTURE
//   Package edge_event_pkg: CHW / count-width localparams, event field widths,
//     request-index encoding (ch*2 + is_fall) and decode helpers.
//   Sub-module edge_event_fifo: synchronous FIFO, parameter width/depth, push/pop,
//     full/empty/count; arbiter and pending logic stay in the top.
// TESTING
//   1 reset: reset_n=0 mid-stream with 3 events queued -> evt_valid=0, count=0 at once.
//   2 single: rise_in[2] pulse at t -> evt_valid=1 after t+1, channel=2, rising=1.
//   3 fairness: rise_in[0..3] all pulsed same cycle -> pops in order 0,1,2,3;
//     repeat with rr_ptr=5 -> order 3,0,1,2.
//   4 full: evt_ready=0, 6 edges on distinct bits, depth 4 -> count=4, 2 pending,
//     then ready=1 -> all 6 delivered, overflow=0.
//   5 loss: fall_in[1] twice while FIFO full -> overflow=1; overflow_clr -> 0.
//   6 TS_EN: counter at 0xFE/0xFF/0x00 -> three events carry wrapped stamps in order.

Source files
------------

// File: rtl/edge_event_pkg.sv
// edge_event_pkg: shared widths and request-index encoding for the edge event arbiter
// Request index encoding: idx = ch*2 + is_fall, so even bits are rising edges and odd bits falling.
package edge_event_pkg;
   localparam int NUM_CH_DEF     = 4;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int TS_WIDTH_DEF   = 8;
   localparam int CHW_DEF        = $clog2(NUM_CH_DEF);
   localparam int CNTW_DEF       = $clog2(FIFO_DEPTH_DEF) + 1;
   localparam int DIR_W          = 1;
   function automatic int req_idx(int ch, bit is_fall);
      return ch * 2 + int'(is_fall);
   endfunction
   function automatic int req_ch(int idx);
      return idx / 2;
   endfunction
   function automatic bit req_fall(int idx);
      return (idx % 2) == 1;
   endfunction
   // single-step modular wrap; callers never exceed 2*n-1
   function automatic int req_wrap(int idx, int n);
      return idx >= n ? idx - n : idx;
   endfunction
endpackage

// File: rtl/edge_event_fifo.sv
// edge_event_fifo: synchronous FIFO with occupancy count
// Ports: clk, reset_n (async active-low), push/din, pop/dout, full, empty, count (0..D).
// push while full and pop while empty are ignored; dout reads 0 while empty.
module edge_event_fifo
#(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               push,
   input  logic [W-1:0]       din,
   input  logic               pop,
   output logic [W-1:0]       dout,
   output logic               full,
   output logic               empty,
   output logic [$clog2(D):0] count
);
   localparam int AW = $clog2(D);
   logic [W-1:0]  mem [D];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign full    = count == (AW+1)'(D);
   assign empty   = count == '0;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: round-robin collection of per-channel edge pulses into an event FIFO
// Ports: clk, reset_n (async active-low); rise_in/fall_in per-channel edge pulses;
//   evt_valid/evt_ready handshake with evt_channel, evt_rising (and evt_timestamp) as FIFO head;
//   fifo_count occupancy; overflow sticky loss flag cleared by overflow_clr.
// Macro EDGE_EVENT_TS_EN adds a free-running stamp captured at grant and the evt_timestamp port.
module edge_event_arbiter
   import edge_event_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int TS_WIDTH   = TS_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_CH-1:0]           rise_in,
   input  logic [NUM_CH-1:0]           fall_in,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [$clog2(NUM_CH)-1:0]   evt_channel,
   output logic                        evt_rising,
`ifdef EDGE_EVENT_TS_EN
   output logic [TS_WIDTH-1:0]         evt_timestamp,
`endif
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   input  logic                        overflow_clr
);
   localparam int CHW = $clog2(NUM_CH);
   localparam int RW  = 2 * NUM_CH;
   localparam int RIW = $clog2(RW);
`ifdef EDGE_EVENT_TS_EN
   localparam int DW  = TS_WIDTH + CHW + DIR_W;
`else
   localparam int DW  = CHW + DIR_W;
`endif
   logic [RW-1:0]  pls, pend, gnt_oh, lost;
   logic [RIW-1:0] rr_ptr, gnt_idx;
   logic           gnt_ok, full, empty;
   logic [DW-1:0]  push_data, head;
   always_comb begin
      pls = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pls[RIW'(req_idx(c, 1'b0))] = rise_in[c];
         pls[RIW'(req_idx(c, 1'b1))] = fall_in[c];
      end
   end
   // scan downwards so the last hit is the first set bit at or after rr_ptr
   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = rr_ptr;
      for (int i = RW - 1; i >= 0; i--)
         if (pend[RIW'(req_wrap(int'(rr_ptr) + i, RW))]) begin
            gnt_ok  = 1'b1;
            gnt_idx = RIW'(req_wrap(int'(rr_ptr) + i, RW));
         end
      gnt_ok = gnt_ok & ~full;
      gnt_oh = gnt_ok ? RW'(1) << gnt_idx : '0;
      lost   = pls & pend & ~gnt_oh;
   end
   // a fresh pulse re-arms a bit being granted in the same cycle
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pend     <= '0;
         rr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         pend     <= (pend & ~gnt_oh) | pls;
         rr_ptr   <= gnt_ok ? RIW'(req_wrap(int'(gnt_idx) + 1, RW)) : rr_ptr;
         overflow <= |lost | (overflow & ~overflow_clr);
      end
`ifdef EDGE_EVENT_TS_EN
   logic [TS_WIDTH-1:0] ts;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ts <= '0;
      else ts <= ts + 1'b1;
   assign push_data     = {ts, CHW'(req_ch(int'(gnt_idx))), ~req_fall(int'(gnt_idx))};
   assign evt_timestamp = head[DW-1 -: TS_WIDTH];
`else
   assign push_data = {CHW'(req_ch(int'(gnt_idx))), ~req_fall(int'(gnt_idx))};
`endif
   assign evt_valid                 = ~empty;
   assign {evt_channel, evt_rising} = head[CHW:0];
   edge_event_fifo #(.W(DW), .D(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (gnt_ok),
      .din     (push_data),
      .pop     (evt_valid & evt_ready),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );
endmodule
